// File: rtl/game_pkg.sv
// Shared game constants: ASCII codes for the score line, UART defaults,
// the byte-FSM state type and the digit-to-ASCII helper.
package game_pkg;

    localparam int unsigned CLK_HZ      = 12_000_000;
    localparam int unsigned BAUD        = 115200;
    localparam int unsigned FRAME_BYTES = 9;

    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_Q  = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } byte_state_t;

    // BCD nibble to ASCII; non-decimal nibbles show as '?'
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_Q : (ASCII_0 + {4'h0, d});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
// Ports: clk, rst_n (async active-low), load (start byte `data`),
//        tx (serial out, idle high), busy (byte in flight),
//        byte_done (high during the last cycle of the stop bit, so the
//        caller can load the next byte with no idle gap).
module uart_tx_byte
    import game_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    byte_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Byte FSM with baud and bit counters; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state   <= ST_START;
                        tx      <= 1'b0;
                        shreg   <= data;
                        cnt     <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Flag one cycle early so byte_done lines up with the final stop cycle
                    if (cnt == CNT_PRE) begin
                        byte_done <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (load) begin
                            state   <= ST_START;
                            tx      <= 1'b0;
                            shreg   <= data;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/score_uart_tx.sv
// Sends the 6-digit BCD score as "S" + digits + CR + LF over 8N1 UART.
// Ports: clk, rst_n (async active-low), send (one-cycle request),
//        score_bcd (6 packed BCD digits, MSD first), busy (frame in flight),
//        done (pulse after the LF stop bit), tx (serial out, idle high).
module score_uart_tx
    import game_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [23:0] score_bcd,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam logic [3:0] IDX_LAST = 4'(FRAME_BYTES - 1);

    logic [23:0] score_q;
    logic [3:0]  idx;
    logic        byte_busy;
    logic        byte_done;
    logic        accept_c;
    logic        more_c;
    logic        load_c;
    logic [3:0]  next_idx_c;
    logic [7:0]  data_c;

    assign accept_c   = send && !busy && !byte_busy;
    assign more_c     = byte_done && busy && (idx < IDX_LAST);
    assign load_c     = accept_c || more_c;
    assign next_idx_c = accept_c ? 4'd0 : (idx + 4'd1);

    // Byte selected for the next load; index 0 never needs the latched score
    always_comb begin
        data_c = ASCII_S;
        case (next_idx_c)
            4'd0:    data_c = ASCII_S;
            4'd1:    data_c = digit_ascii(score_q[23:20]);
            4'd2:    data_c = digit_ascii(score_q[19:16]);
            4'd3:    data_c = digit_ascii(score_q[15:12]);
            4'd4:    data_c = digit_ascii(score_q[11:8]);
            4'd5:    data_c = digit_ascii(score_q[7:4]);
            4'd6:    data_c = digit_ascii(score_q[3:0]);
            4'd7:    data_c = ASCII_CR;
            4'd8:    data_c = ASCII_LF;
            default: data_c = ASCII_S;
        endcase
    end

    // Frame sequencer: score latch, byte index, busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                score_q <= score_bcd;
                idx     <= '0;
                busy    <= 1'b1;
            end else if (byte_done && busy) begin
                if (more_c) begin
                    idx <= idx + 4'd1;
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .data     (data_c),
        .tx       (tx),
        .busy     (byte_busy),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_score_uart_tx.sv
module tb_score_uart_tx;

    localparam int unsigned CPB       = 104;
    localparam int unsigned NBYTES    = 9;
    localparam int unsigned FRAME_CYC = NBYTES * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [23:0] score_bcd = '0;
    logic        busy;
    logic        done;
    logic        tx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    score_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .send     (send),
        .score_bcd(score_bcd),
        .busy     (busy),
        .done     (done),
        .tx       (tx)
    );

    initial begin
        #(5_000_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [23:0] s, input int i);
        logic [3:0] n;
        if (i == 0) return 8'h53;
        if (i == 7) return 8'h0D;
        if (i == 8) return 8'h0A;
        n = s[23 - 4*(i-1) -: 4];
        return (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
    endfunction

    task automatic push_frame(input logic [23:0] s);
        for (int i = 0; i < int'(NBYTES); i++) sb_q.push_back(model_byte(s, i));
    endtask

    // Pulse send; leaves the bench at the negedge of the first start-bit cycle
    task automatic send_pulse(input logic [23:0] s, input bit push);
        @(posedge clk);
        #1;
        send = 1'b1;
        score_bcd = s;
        if (push) push_frame(s);
        @(posedge clk);
        #1;
        send = 1'b0;
        @(negedge clk);
        chk("start_latency_tx", 32'(tx), 32'd0);
        chk("start_latency_busy", 32'(busy), 32'd1);
    endtask

    // Samples one 10-bit character starting at the current negedge
    task automatic recv_byte(output logic [9:0] bits, output bit width_ok, output bit busy_ok);
        width_ok = 1'b1;
        busy_ok  = 1'b1;
        bits     = '0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < int'(CPB); j++) begin
                if (!(k == 0 && j == 0)) @(negedge clk);
                if (j == 0) bits[k] = tx;
                else if (tx !== bits[k]) width_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
    endtask

    task automatic recv_frame(input string tag, input bit b2b, input logic [23:0] s2);
        logic [9:0] bits;
        logic [7:0] exp_b;
        bit w, bz;
        bit all_w = 1'b1, all_bz = 1'b1, framing = 1'b1, contig = 1'b1;
        int start_cyc;
        start_cyc = cyc;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (tx !== 1'b0) contig = 1'b0;
            end
            recv_byte(bits, w, bz);
            all_w  &= w;
            all_bz &= bz;
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) framing = 1'b0;
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
                exp_b = sb_q.pop_front();
                chk({tag, "_byte"}, 32'(bits[8:1]), 32'(exp_b));
            end
        end
        chk({tag, "_bit_width"}, 32'(all_w), 32'd1);
        chk({tag, "_busy_during"}, 32'(all_bz), 32'd1);
        chk({tag, "_framing"}, 32'(framing), 32'd1);
        chk({tag, "_no_gap"}, 32'(contig), 32'd1);
        @(negedge clk);
        chk({tag, "_frame_len"}, 32'(cyc - start_cyc), 32'(FRAME_CYC));
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
        if (b2b) begin
            send = 1'b1;
            score_bcd = s2;
            push_frame(s2);
            @(posedge clk);
            #1;
            send = 1'b0;
            @(negedge clk);
            chk({tag, "_b2b_start_tx"}, 32'(tx), 32'd0);
            chk({tag, "_b2b_start_busy"}, 32'(busy), 32'd1);
        end else begin
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        bit idle_ok;

        // Reset and idle
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
        end
        chk("idle_quiet", 32'(idle_ok), 32'd1);

        // Single frame, then back-to-back frame from the done cycle
        send_pulse(24'h177013, 1'b1);
        recv_frame("f177013", 1'b1, 24'h000001);
        recv_frame("b2b", 1'b0, 24'h0);

        // Invalid digits; a mid-frame send must be ignored
        send_pulse(24'h00A0F9, 1'b1);
        fork
            recv_frame("inval", 1'b0, 24'h0);
            begin
                repeat (3000) @(posedge clk);
                #1;
                send = 1'b1;
                score_bcd = 24'h999999;
                @(posedge clk);
                #1;
                send = 1'b0;
            end
        join
        idle_ok = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("no_second_frame", 32'(idle_ok), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during byte 3 data bits
        send_pulse(24'h123456, 1'b0);
        repeat (3 * 10 * CPB + 400) @(negedge clk);
        chk("midframe_tx_low_bit_pending", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle_tx", 32'(tx), 32'd1);
        send_pulse(24'h000000, 1'b1);
        recv_frame("post_rst", 1'b0, 24'h0);
        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_uart_tx.md
Name: score_uart_tx

Overview:
Transmits the current game score out of the board's `tx` pin as a short ASCII line over 8N1 UART. A gameplay event pulses `send` with a 6-digit packed-BCD score. The block latches the score and serializes the frame "S" + 6 digits + CR + LF. It sits beside the VGA path in the top level and replaces the constant-0 `tx` drive; it is the transmit counterpart of the board's `rx` serial line.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200 baud, truncated); legal range 2..65535
FRAME_BYTES, 9, bytes per frame: 'S', 6 digits, CR, LF; fixed, not to be overridden

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
send  input  1  one-cycle request to transmit `score_bcd`
score_bcd  input  24  6 BCD digits; [23:20] is most significant and sent first
busy  output  1  high from the cycle after `send` is accepted until the frame completes
done  output  1  one-cycle pulse when the last stop bit of LF ends
tx  output  1  UART serial out, idle high

Behaviour:
- Reset (async, rst_n=0): `tx`=1, `busy`=0, `done`=0; FSM=IDLE; all counters cleared; latched score cleared. An in-flight frame is abandoned with no partial-byte completion; `tx` returns high immediately.
- Accept: `send`=1 while `busy`=0 latches `score_bcd` and sets byte index=0. Next cycle: `busy`=1, `tx`=0 (start bit of byte 0).
- `send` while `busy`=1 is ignored; the latched score is never updated mid-frame.
- Byte sequence: 0x53, then 0x30+digit for digits [23:20] down to [3:0], then 0x0D, 0x0A.
- Any digit nibble >9 is sent as 0x3F ('?').
- Per byte: start bit 0; 8 data bits LSB first; stop bit 1. Each bit holds `tx` for exactly CLKS_PER_BIT cycles.
- The next byte's start bit follows the previous stop bit with no idle gap.
- Frame length: FRAME_BYTES*10*CLKS_PER_BIT cycles, which is 9360 at default.
- Byte FSM states:
  - IDLE -> START on accept, or on byte-load from the frame sequencer.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits; bit counter 0..7.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Frame sequencer: on byte-done, if index < FRAME_BYTES-1, increment the index and load the next byte in the same cycle. Otherwise pulse `done` and drop `busy` in that cycle.
- Back-to-back: `send` asserted in the cycle `done`=1 (and `busy`=0) is accepted. The new start bit begins the following cycle.
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It is never free-running in IDLE.
- All outputs are registered; `tx` has no combinational path from inputs.

Decomposition:
- Shared package `game_pkg`:
  - ASCII constants ASCII_S=8'h53, ASCII_0=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_Q=8'h3F.
  - Default CLK_HZ=12_000_000 and BAUD=115200 constants.
- One sub-module `uart_tx_byte`:
  - Parameter CLKS_PER_BIT.
  - Ports clk, rst_n, load, data[7:0], tx, busy, byte_done.
  - Contains the baud counter, bit counter and byte FSM.
- `score_uart_tx` holds the latch, byte index, digit-to-ASCII mux and the done/busy logic.

Test Plan:
- Reset idle: hold rst_n=0 for 5 cycles, release with no `send` for 1000 cycles -> `tx`=1, `busy`=0, `done`=0 throughout.
- Single frame: `score_bcd`=24'h177013, `send` pulse -> bench UART monitor decodes bytes 53 31 37 37 30 31 33 0D 0A. `done` pulses exactly 9360 cycles after the first start bit falls; `busy` is high for those 9360 cycles.
- Bit timing: same frame -> every bit width is exactly 104 cycles; first `tx` falling edge is 1 cycle after `send`.
- Invalid digit and ignored send: `score_bcd`=24'h00A0F9, then `send` with `score_bcd`=24'h999999 mid-frame -> bytes 53 30 30 3F 30 3F 39 0D 0A; no second frame follows.
- Back-to-back: `send` asserted in the `done` cycle with 24'h000001 -> second frame starts the next cycle with no idle bits and decodes 53 30 30 30 30 30 31 0D 0A.
- Reset mid-frame: assert rst_n=0 during byte 3 data bits -> `tx`=1 and `busy`=0 asynchronously. After release, a new `send` of 24'h000000 produces a clean full frame.
